// File: rtl/axis_frame_tester.sv
`timescale 1ns/1ps
// axis_frame_tester
// AXI-Stream frame generator/checker used as the harness end of a loopback or
// frame-buffer path. On start it transmits one FRAME_LEN-beat frame whose beats
// are seed+index (modulo 2^DATA_WIDTH) and checks the frame that comes back:
// data, beat count and tlast placement. TX and RX run independently, so both
// cut-through and store-and-forward DUTs work.
//
// Ports
//   aclk, aresetn            clock, synchronous active-low reset
//   start, seed              start pulse (accepted in IDLE/DONE), pattern base
//   m_axis_t{data,valid,last}/m_axis_tready   generated frame towards the DUT
//   s_axis_t{data,valid,last}/s_axis_tready   returned frame from the DUT
//   busy                     run in progress
//   done                     run finished (sticky until next start or reset)
//   pass                     done with no errors and no timeout
//   timeout                  RX side went idle for TIMEOUT cycles
//   err_count                saturating data/tlast error count
//   rx_count                 RX beats accepted this run
//
// Build option
//   AXIS_TESTER_BACKPRESSURE_EN  when defined, s_axis_tready is gated by an
//   8-bit LFSR (x^8+x^6+x^5+x^4+1, reloaded with 8'hA5 on start) to make the
//   DUT hold tvalid. When undefined the RX side is always ready while active.
module axis_frame_tester #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 768,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           err_count,
    output logic [9:0]            rx_count
);

    localparam int IDX_W  = 10;
    localparam int IDLE_W = $clog2(TIMEOUT);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] seed_q;
    logic [IDX_W-1:0]      tx_idx;
    logic [IDX_W-1:0]      rx_idx;
    logic [IDLE_W-1:0]     idle_cnt;
    logic                  tx_done;
    logic                  rx_done;

    logic                  start_acc;
    logic                  rx_active;
    logic                  tx_hs;
    logic                  rx_hs;
    logic                  idle_expired;
    logic [IDX_W-1:0]      tx_idx_nx;

    logic [DATA_WIDTH-1:0] rx_expected;
    logic                  rx_last_beat;
    logic                  data_err;
    logic                  tlast_err;
    logic [16:0]           err_sum;
    logic [15:0]           err_next;

    assign start_acc = start && (state_q != S_RUN);
    assign rx_active = (state_q == S_RUN) && !rx_done;

`ifdef AXIS_TESTER_BACKPRESSURE_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;

    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge aclk) begin
        if (!aresetn || start_acc) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    assign s_axis_tready = rx_active && lfsr[0];
`else
    assign s_axis_tready = rx_active;
`endif

    assign tx_hs     = m_axis_tvalid && m_axis_tready;
    assign rx_hs     = s_axis_tvalid && s_axis_tready;
    assign tx_idx_nx = tx_idx + IDX_W'(1);

    // Idle limit is judged on the cycle itself: a handshake in the final
    // cycle still rescues the run.
    assign idle_expired = (state_q == S_RUN) && !rx_hs && (idle_cnt == IDLE_LAST);

    // RX checking: a data error and a tlast error on the same beat count twice.
    assign rx_expected  = seed_q + DATA_WIDTH'(rx_idx);
    assign rx_last_beat = (rx_idx == LAST_IDX);
    assign data_err     = (s_axis_tdata != rx_expected);
    assign tlast_err    = (s_axis_tlast && !rx_last_beat) || (rx_last_beat && !s_axis_tlast);
    assign err_sum      = {1'b0, err_count} + 17'(data_err) + 17'(tlast_err);
    assign err_next     = err_sum[16] ? '1 : err_sum[15:0];

    assign rx_count = rx_idx;

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (idle_expired || (tx_done && rx_done)) state_d = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
        pass = done && (err_count == '0) && !timeout;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            seed_q        <= '0;
            tx_idx        <= '0;
            rx_idx        <= '0;
            idle_cnt      <= '0;
            tx_done       <= 1'b0;
            rx_done       <= 1'b0;
            err_count     <= '0;
            timeout       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                seed_q        <= seed;
                tx_idx        <= '0;
                rx_idx        <= '0;
                idle_cnt      <= '0;
                tx_done       <= 1'b0;
                rx_done       <= 1'b0;
                err_count     <= '0;
                timeout       <= 1'b0;
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= seed;
                m_axis_tlast  <= 1'b0;
            end else if (state_q == S_RUN) begin
                // TX: outputs only move on a handshake, so they hold under stall.
                if (tx_hs) begin
                    if (tx_idx == LAST_IDX) begin
                        tx_done       <= 1'b1;
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                    end else begin
                        tx_idx       <= tx_idx_nx;
                        m_axis_tdata <= seed_q + DATA_WIDTH'(tx_idx_nx);
                        m_axis_tlast <= (tx_idx_nx == LAST_IDX);
                    end
                end
                // RX and idle watchdog; timeout also drops TX valid.
                if (rx_hs) begin
                    rx_idx    <= rx_idx + IDX_W'(1);
                    err_count <= err_next;
                    idle_cnt  <= '0;
                    if (rx_last_beat || s_axis_tlast) rx_done <= 1'b1;
                end else if (idle_expired) begin
                    timeout       <= 1'b1;
                    m_axis_tvalid <= 1'b0;
                end else begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
            end
        end
    end

endmodule
